date: RTL and testbench
=======================

# date

Day-of-month / month-of-year stage of the century clock. Advances a BCD day and month once per day tick. Applies calendar month lengths, including Gregorian leap years computed from the year digits fed back from the year stage. Produces the one-cycle carry that enables the year stage at the 31 December → 1 January rollover, and accepts a validated synchronous load for setting the date.

## Interface
Parameters: none (calendar rules are fixed).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  day tick from the hour stage; one cycle high per day rollover
- year_0  input  4  BCD year units, from the year stage
- year_1  input  4  BCD year tens
- year_2  input  4  BCD year hundreds
- year_3  input  4  BCD year thousands
- load  input  1  load request for load_day/load_month
- load_day  input  8  BCD day to load; [7:4] tens, [3:0] units
- load_month  input  8  BCD month to load; [7:4] tens, [3:0] units
- day_0  output  4  BCD day units
- day_1  output  4  BCD day tens
- month_0  output  4  BCD month units
- month_1  output  4  BCD month tens
- year_en  output  1  combinational carry to the year stage's en
- load_err  output  1  registered; high one cycle after a rejected load

## Operation
- **Reset.** While rst=1 at an edge: day = 01, month = 01, load_err = 0. rst has priority over load and en.
- **Priority.** Order is rst > load > en. If load=1, en is ignored in that cycle and no advance occurs, valid load or not.
- **Month length.** Months 01, 03, 05, 07, 08, 10, 12 have 31 days. Months 04, 06, 09, 11 have 30 days. Month 02 has 29 days if leap, else 28.
- **Leap rule.** leap = (Y mod 4 == 0) and ((Y mod 100 != 0) or (Y mod 400 == 0)), evaluated directly on BCD digits:
  - Two-digit value d1d0 divisible by 4: (d1 even and d0 ∈ {0,4,8}) or (d1 odd and d0 ∈ {2,6}).
  - Y mod 100 == 0: year_1 == 0 and year_0 == 0.
  - In that case, Y mod 400 == 0 iff year_3:year_2 is divisible by 4 under the same two-digit rule.
- **Advance (en=1, no load).**
  - If day < month length: increment day in BCD (units 9 → 0 with tens +1), month unchanged.
  - If day == month length: day → 01 and month increments in BCD.
  - From month 12: month → 01.
- **year_en.** year_en = en & ~load & ~rst & (day == 31) & (month == 12). It is combinational, so the year stage increments on the same edge at which the date wraps to 01-01.
- **Load validation.** A load is valid iff all of the following hold; the leap check uses the year inputs present in the load cycle:
  - Every digit is ≤ 9.
  - Month is in 01..12.
  - Day is in 01..(length of the loaded month).
- **Load outcome.**
  - Valid: day and month take the loaded values at that edge; load_err = 0 next cycle.
  - Invalid: day and month hold; load_err = 1 for exactly the next cycle.
- **Out-of-range state.** Outputs never hold an out-of-range date. Reset and loads are the only entry points, and both are constrained.

## Timing
- Day and month update on the edge where en or load is sampled; outputs change one edge after the request.
- year_en has zero latency: same cycle as the en that causes 31-12 → 01-01.
- load_err is registered: it asserts in the cycle after the rejected load and deasserts on the following edge unless another invalid load occurs.
- The Feb 28/29 decision uses year_0..year_3 as sampled at that edge; the year stage does not change on those edges.
- en held high for consecutive cycles advances one day per cycle; there is no internal edge detection.
- Reset mid-sequence, including in the 31-12 cycle with en=1: the date becomes 01-01 and year_en = 0, so no year carry.

## Test plan
- **Reset and advance.** Assert rst → day=01, month=01, load_err=0. Then 31 en pulses → 01-02, with year_en never high.
- **Year-end rollover.** Load 31-12, then one en → year_en=1 in that cycle; next state 01-01.
- **Leap years.**
  - Year 2024 at 28-02 + en → 29-02; next en → 01-03.
  - Year 2023 at 28-02 + en → 01-03.
  - Year 1900 at 28-02 + en → 01-03.
  - Year 2000 at 28-02 + en → 29-02.
- **Month lengths.** 30-04 + en → 01-05. 30-01 + en → 31-01. 31-07 + en → 01-08.
- **Load rejection.** Each of the following leaves the date unchanged and gives load_err=1 for one cycle:
  - 31-04
  - 29-02 with year 2023
  - 00-05
  - 15-13
  - day units 0xA

  29-02 with year 2024 is accepted with load_err=0.
- **Load vs en.** load=1 and en=1 on 31-12 with valid load 10-06 → year_en=0, state 10-06, no advance.

Source files
------------

// File: rtl/date.sv
// Day/month stage of the century clock: BCD day and month with Gregorian month lengths,
// a year carry at the 31-12 rollover, and a validated synchronous load.
module date (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] year_0,
  input  logic [3:0] year_1,
  input  logic [3:0] year_2,
  input  logic [3:0] year_3,
  input  logic       load,
  input  logic [7:0] load_day,
  input  logic [7:0] load_month,
  output logic [3:0] day_0,
  output logic [3:0] day_1,
  output logic [3:0] month_0,
  output logic [3:0] month_1,
  output logic       year_en,
  output logic       load_err
);

  logic [7:0] day_q, day_d;
  logic [7:0] month_q, month_d;
  logic       load_err_q, load_err_d;
  logic       leap;
  logic [7:0] cur_len, load_len;
  logic       load_valid;

  // Two-digit BCD value divisible by 4.
  function automatic logic bcd_div4(input logic [3:0] d1, input logic [3:0] d0);
    logic even_ok, odd_ok;
    even_ok = (d0 == 4'd0) || (d0 == 4'd4) || (d0 == 4'd8);
    odd_ok  = (d0 == 4'd2) || (d0 == 4'd6);
    return d1[0] ? odd_ok : even_ok;
  endfunction

  // Last day of a BCD month; unused months fall back to 31 and are rejected elsewhere.
  function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
    logic [7:0] len;
    unique case (m)
      8'h04, 8'h06, 8'h09, 8'h11: len = 8'h30;
      8'h02:                      len = lp ? 8'h29 : 8'h28;
      default:                    len = 8'h31;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Century years are leap only when the century number itself is divisible by 4.
  always_comb begin
    if ((year_1 == 4'd0) && (year_0 == 4'd0)) leap = bcd_div4(year_3, year_2);
    else                                      leap = bcd_div4(year_1, year_0);
  end

  assign cur_len  = month_len(month_q, leap);
  assign load_len = month_len(load_month, leap);

  // BCD digits compare correctly as plain 8-bit values once every digit is <= 9.
  always_comb begin
    load_valid = (load_day[7:4] <= 4'd9) && (load_day[3:0] <= 4'd9) &&
                 (load_month[7:4] <= 4'd9) && (load_month[3:0] <= 4'd9) &&
                 (load_month >= 8'h01) && (load_month <= 8'h12) &&
                 (load_day >= 8'h01) && (load_day <= load_len);
  end

  always_comb begin
    day_d      = day_q;
    month_d    = month_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_valid) begin
        day_d   = load_day;
        month_d = load_month;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (day_q == cur_len) begin
        day_d   = 8'h01;
        month_d = (month_q == 8'h12) ? 8'h01 : bcd_inc(month_q);
      end else begin
        day_d = bcd_inc(day_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q      <= 8'h01;
      month_q    <= 8'h01;
      load_err_q <= 1'b0;
    end else begin
      day_q      <= day_d;
      month_q    <= month_d;
      load_err_q <= load_err_d;
    end
  end

  assign year_en  = en & ~load & ~rst & (day_q == 8'h31) & (month_q == 8'h12);
  assign day_0    = day_q[3:0];
  assign day_1    = day_q[7:4];
  assign month_0  = month_q[3:0];
  assign month_1  = month_q[7:4];
  assign load_err = load_err_q;

endmodule

// File: tb/tb_date.sv
// Directed self-checking bench for the date stage: reset, advance, leap years,
// month lengths, load rejection and load/en priority.
module tb_date;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] yr;
  logic [7:0]  load_day, load_month;
  logic [3:0]  day_0, day_1, month_0, month_1;
  logic        year_en, load_err;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  date dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .year_0    (yr[3:0]),
    .year_1    (yr[7:4]),
    .year_2    (yr[11:8]),
    .year_3    (yr[15:12]),
    .load      (load),
    .load_day  (load_day),
    .load_month(load_month),
    .day_0     (day_0),
    .day_1     (day_1),
    .month_0   (month_0),
    .month_1   (month_1),
    .year_en   (year_en),
    .load_err  (load_err)
  );

  wire [15:0] dm = {day_1, day_0, month_1, month_0};

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d, input logic [7:0] m);
    load = 1'b1; load_day = d; load_month = m;
    cycle();
    load = 1'b0;
  endtask

  task automatic step_en();
    en = 1'b1;
    cycle();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; load_day = 8'h00; load_month = 8'h00; yr = 16'h2023;
    cycle(); cycle();
    rst = 1'b0;
    checks++;
    if (dm !== 16'h0101) begin errors++; $display("FAIL reset_date got %h want 0101", dm); end
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", load_err); end
  endtask

  task automatic test_advance();
    logic saw_carry = 1'b0;
    for (int i = 0; i < 31; i++) begin
      en = 1'b1; #1;
      if (year_en !== 1'b0) saw_carry = 1'b1;
      cycle();
    end
    en = 1'b0;
    checks++;
    if (dm !== 16'h0102) begin errors++; $display("FAIL advance31 got %h want 0102", dm); end
    checks++;
    if (saw_carry !== 1'b0) begin errors++; $display("FAIL advance_carry got %b want 0", saw_carry); end
  endtask

  task automatic test_year_end();
    yr = 16'h2023;
    do_load(8'h31, 8'h12);
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL ye_load_err got %b want 0", load_err); end
    en = 1'b1; #1;
    checks++;
    if (year_en !== 1'b1) begin errors++; $display("FAIL ye_carry got %b want 1", year_en); end
    cycle(); en = 1'b0; #1;
    checks++;
    if (dm !== 16'h0101) begin errors++; $display("FAIL ye_wrap got %h want 0101", dm); end
    checks++;
    if (year_en !== 1'b0) begin errors++; $display("FAIL ye_carry_off got %b want 0", year_en); end
  endtask

  task automatic test_reset_mid();
    do_load(8'h31, 8'h12);
    en = 1'b1; rst = 1'b1; #1;
    checks++;
    if (year_en !== 1'b0) begin errors++; $display("FAIL rstmid_carry got %b want 0", year_en); end
    cycle(); en = 1'b0; rst = 1'b0;
    checks++;
    if (dm !== 16'h0101) begin errors++; $display("FAIL rstmid_date got %h want 0101", dm); end
  endtask

  task automatic test_leap();
    logic [15:0] years [4] = '{16'h2024, 16'h2023, 16'h1900, 16'h2000};
    logic [15:0] want  [4] = '{16'h2902, 16'h0103, 16'h0103, 16'h2902};
    for (int i = 0; i < 4; i++) begin
      yr = years[i];
      do_load(8'h28, 8'h02);
      step_en();
      checks++;
      if (dm !== want[i])
        begin errors++; $display("FAIL leap_%h got %h want %h", years[i], dm, want[i]); end
    end
    yr = 16'h2024;
    do_load(8'h29, 8'h02);
    step_en();
    checks++;
    if (dm !== 16'h0103) begin errors++; $display("FAIL leap_end got %h want 0103", dm); end
  endtask

  task automatic test_month_len();
    logic [15:0] start [5] = '{16'h3004, 16'h3001, 16'h3107, 16'h3009, 16'h0901};
    logic [15:0] want  [5] = '{16'h0105, 16'h3101, 16'h0108, 16'h0110, 16'h1001};
    yr = 16'h2023;
    for (int i = 0; i < 5; i++) begin
      do_load(start[i][15:8], start[i][7:0]);
      step_en();
      checks++;
      if (dm !== want[i])
        begin errors++; $display("FAIL mlen_%h got %h want %h", start[i], dm, want[i]); end
    end
  endtask

  task automatic test_load_reject();
    logic [15:0] bad [5] = '{16'h3104, 16'h2902, 16'h0005, 16'h1513, 16'h1A05};
    yr = 16'h2023;
    do_load(8'h15, 8'h06);
    for (int i = 0; i < 5; i++) begin
      do_load(bad[i][15:8], bad[i][7:0]);
      checks++;
      if (load_err !== 1'b1)
        begin errors++; $display("FAIL rej_err_%h got %b want 1", bad[i], load_err); end
      checks++;
      if (dm !== 16'h1506)
        begin errors++; $display("FAIL rej_hold_%h got %h want 1506", bad[i], dm); end
      cycle();
      checks++;
      if (load_err !== 1'b0)
        begin errors++; $display("FAIL rej_clear_%h got %b want 0", bad[i], load_err); end
    end
    yr = 16'h2024;
    do_load(8'h29, 8'h02);
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL acc_err got %b want 0", load_err); end
    checks++;
    if (dm !== 16'h2902) begin errors++; $display("FAIL acc_date got %h want 2902", dm); end
  endtask

  task automatic test_load_vs_en();
    do_load(8'h31, 8'h12);
    load = 1'b1; load_day = 8'h10; load_month = 8'h06; en = 1'b1; #1;
    checks++;
    if (year_en !== 1'b0) begin errors++; $display("FAIL lve_carry got %b want 0", year_en); end
    cycle(); load = 1'b0; en = 1'b0;
    checks++;
    if (dm !== 16'h1006) begin errors++; $display("FAIL lve_date got %h want 1006", dm); end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_year_end();
    test_reset_mid();
    test_leap();
    test_month_len();
    test_load_reject();
    test_load_vs_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
